// File: rtl/booth_operand_sequencer_pkg.sv
// Shared types and constants for the Booth operand sequencer.
// Covers the FSM encoding, datapath widths, the timeout sentinel and the FIFO entry layout.
package booth_operand_sequencer_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [PROD_W-1:0] TIMEOUT_SENTINEL = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    HOLD  = 2'b11
  } seq_state_t;

  // One FIFO entry: multiplicand in the upper byte, multiplier in the lower byte.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/booth_operand_fifo.sv
// Synchronous DEPTH x W operand FIFO with an occupancy count.
// The head entry is always visible on rdata; DEPTH must be a power of two.
module booth_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                   clock,
  input  logic                   _reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Operand sequencer for the 8-bit Booth multiplier: it queues operand pairs, issues one multiply
// at a time and presents each product on a valid/ready port. Define BOOTH_SEQ_TIMEOUT_EN to enable the WAIT timeout.
module booth_operand_sequencer
  import booth_operand_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   _reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_a,
  input  logic [OP_W-1:0]        in_b,
  output logic                   mul_start,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic                   mul_done,
  input  logic [PROD_W-1:0]      mul_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PROD_W-1:0]      out_result,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
`ifdef BOOTH_SEQ_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  seq_state_t          state;
  op_pair_t            head;
  logic [PROD_W-1:0]   head_raw;
  logic                full, empty, pop, timed_out;

  assign in_ready = !full;
  assign busy     = (state != IDLE);
  assign head     = head_raw;

  booth_operand_fifo #(.DEPTH(DEPTH), .W(PROD_W)) u_fifo (
    .clock  (clock),
    ._reset (_reset),
    .push   (in_valid),
    .pop    (pop),
    .wdata  ({in_a, in_b}),
    .rdata  (head_raw),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Fires on the TIMEOUT-th WAIT cycle; a done arriving in that same cycle still wins.
  assign timed_out = (state == WAIT) && !mul_done && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else if (!mul_done) wait_cnt <= wait_cnt + TW'(1);
      if (timed_out) timeout_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // The head entry leaves the FIFO only once its multiply has finished (or been abandoned).
  assign pop = (state == WAIT) && (mul_done || timed_out);

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state      <= IDLE;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        // A lingering done from the multiplier must fall before the next issue.
        IDLE: if (!empty && !mul_done) begin
          mul_a     <= head.a;
          mul_b     <= head.b;
          mul_start <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          mul_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (mul_done) begin
          out_result <= mul_result;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end else if (timed_out) begin
          out_result <= TIMEOUT_SENTINEL;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Self-checking bench for booth_operand_sequencer: a transaction-level queue model plus a behavioural
// multiplier, checked every cycle, with directed scenarios followed by a randomized phase.
module tb_booth_operand_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        _reset = 1'b0;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_result;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  count;
  logic        busy;
`ifdef BOOTH_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  booth_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    ._reset     (_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .count      (count),
    .busy       (busy)
`ifdef BOOTH_SEQ_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // ---------------- behavioural multiplier ----------------
  int   lat = 4;
  bit   mul_auto = 1'b1;
  bit   mul_mute = 1'b0;
  logic force_done = 1'b0;

  initial begin
    int          cd;
    logic [15:0] p;
    cd = 0;
    p = '0;
    mul_done = 1'b0;
    mul_result = '0;
    forever begin
      @(posedge clock);
      #2;
      if (!_reset) begin
        cd = 0;
        mul_done = mul_auto ? 1'b0 : force_done;
      end else if (!mul_auto) begin
        mul_done = force_done;
      end else begin
        if (mul_done) mul_done = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && !mul_mute) begin
            mul_done = 1'b1;
            mul_result = p;
          end
        end
        if (mul_start) begin
          p = sprod(mul_a, mul_b);
          cd = lat;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  pair_t       opq[$];
  logic [15:0] acc_q[$];
  bit          issuing, waiting, holding, terr_m;
  int          wcnt;
  logic [15:0] hold_val;

  always @(negedge clock) begin
    pair_t pa;
    bit    push_ok;
    if (!_reset) begin
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mul_start", mul_start, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      opq.delete();
      issuing = 0; waiting = 0; holding = 0; terr_m = 0; wcnt = 0;
    end else begin
      chk("count", count, opq.size());
      chk("in_ready", in_ready, 32'(opq.size() < DEPTH));
      chk("mul_start", mul_start, issuing);
      chk("busy", busy, issuing || waiting || holding);
      chk("out_valid", out_valid, holding);
      if (holding) chk("out_result", out_result, hold_val);
      if (issuing || waiting) begin
        chk("mul_a", mul_a, opq[0].a);
        chk("mul_b", mul_b, opq[0].b);
      end
`ifdef BOOTH_SEQ_TIMEOUT_EN
      chk("timeout_err", timeout_err, terr_m);
`endif
      // Advance the model to what must hold after the coming rising edge.
      push_ok = in_valid && (opq.size() < DEPTH);
      pa.a = in_a;
      pa.b = in_b;
      if (issuing) begin
        issuing = 0;
        waiting = 1;
        wcnt = 0;
      end else if (waiting) begin
        wcnt++;
        if (mul_done) begin
          hold_val = sprod(opq[0].a, opq[0].b);
          void'(opq.pop_front());
          waiting = 0;
          holding = 1;
        end
`ifdef BOOTH_SEQ_TIMEOUT_EN
        else if (wcnt == TIMEOUT) begin
          hold_val = 16'hDEAD;
          void'(opq.pop_front());
          terr_m = 1;
          waiting = 0;
          holding = 1;
        end
`endif
      end else if (holding) begin
        if (out_ready) begin
          holding = 0;
          acc_q.push_back(out_result);
        end
      end else if (opq.size() != 0 && !mul_done) begin
        issuing = 1;
      end
      if (push_ok) opq.push_back(pa);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    chk("push_wait", in_ready, 1);
    if (in_ready) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int c = 0;
    while (acc_q.size() < n && c < 500) begin
      @(posedge clock); #1;
      c++;
    end
    chk("acc_wait", 32'(acc_q.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy || count != 0) && c < 500) begin
      @(posedge clock); #1;
      c++;
    end
    chk("idle_wait", busy || (count != 0), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (2) @(negedge clock);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_out_result", out_result, 0);
    @(posedge clock); #1;
    _reset = 1'b1;

    // Single operation, slow multiplier.
    lat = 20; out_ready = 1;
    push(8'h01, 8'hF8);
    wait_acc(1);
    chk("single_prod", acc_q[0], 16'hFFF8);

    // Fill with a stalled consumer; the fifth pair waits for space.
    wait_idle();
    out_ready = 0; lat = 3;
    push(8'h03, 8'h05);
    push(8'hFE, 8'h07);
    push(8'h7F, 8'h7F);
    push(8'h80, 8'h80);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count4", count, 4);
    push(8'h10, 8'h10);
    chk("fill_count_after5", count, 4);
    cycles(3);
    out_ready = 1;
    wait_acc(6);
    chk("fill_p0", acc_q[1], 16'h000F);
    chk("fill_p1", acc_q[2], 16'hFFF2);
    chk("fill_p2", acc_q[3], 16'h3F01);
    chk("fill_p3", acc_q[4], 16'h4000);
    chk("fill_p4", acc_q[5], 16'h0100);

    // Push landing on the same edge as WAIT->HOLD with two entries queued.
    wait_idle();
    lat = 6;
    push(8'h02, 8'h03);
    in_valid = 1; in_a = 8'h04; in_b = 8'hFF;
    cycles(1);
    in_valid = 0;
    chk("sim_issue", mul_start, 1);
    cycles(6);
    chk("sim_pre_count", count, 2);
    in_valid = 1; in_a = 8'hFD; in_b = 8'hFD;
    cycles(1);
    in_valid = 0;
    chk("sim_count", count, 2);
    wait_acc(9);
    chk("sim_p0", acc_q[6], 16'h0006);
    chk("sim_p1", acc_q[7], 16'hFFFC);
    chk("sim_p2", acc_q[8], 16'h0009);

    // A done already high in IDLE holds off the issue.
    wait_idle();
    mul_auto = 0; force_done = 1;
    push(8'h05, 8'hFD);
    repeat (5) begin
      cycles(1);
      chk("stale_no_start", mul_start, 0);
    end
    chk("stale_count", count, 1);
    force_done = 0; mul_auto = 1;
    wait_acc(10);
    chk("stale_prod", acc_q[9], 16'hFFF1);

    // Asynchronous reset in WAIT with three entries queued.
    wait_idle();
    lat = 30;
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    push(8'h03, 8'h03);
    cycles(4);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_count", count, 3);
    #2 _reset = 1'b0;
    #1;
    chk("rst_async_start", mul_start, 0);
    chk("rst_async_count", count, 0);
    chk("rst_async_busy", busy, 0);
    @(negedge clock);
    @(posedge clock); #1;
    _reset = 1'b1;
    @(negedge clock);
    chk("rst_post_out_valid", out_valid, 0);
    @(posedge clock); #1;

    // Randomized traffic with random back-pressure and multiplier latency.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lat       = $urandom_range(1, 8);
      cycles(1);
    end
    in_valid = 0; out_ready = 1;
    wait_idle();

`ifdef BOOTH_SEQ_TIMEOUT_EN
    // Silent multiplier: the entry is abandoned with the sentinel, then service resumes.
    mul_mute = 1;
    base = acc_q.size();
    push(8'h07, 8'h09);
    wait_acc(base + 1);
    chk("to_sentinel", acc_q[base], 16'hDEAD);
    chk("to_err", timeout_err, 1);
    mul_mute = 0;
    push(8'h07, 8'h09);
    wait_acc(base + 2);
    chk("to_next_prod", acc_q[base + 1], 16'h003F);
    chk("to_err_sticky", timeout_err, 1);
`else
    base = acc_q.size();
    push(8'h07, 8'h09);
    wait_acc(base + 1);
    chk("last_prod", acc_q[base], 16'h003F);
`endif

    cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_operand_sequencer.md
Name: booth_operand_sequencer

Overview:
- Upstream/downstream wrapper stage for the 8-bit Booth multiplier datapath.
- Buffers signed operand pairs in a small FIFO and issues one multiply at a time: drives operands, raises start, waits for done, captures the 16-bit product.
- Presents each product on a valid/ready output port.
- Guarantees operands stay stable for the full multiply and that start never overlaps an in-flight operation.

Parameters:
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- TIMEOUT, 64: cycles allowed in WAIT before abort; used only with the optional feature.

Ports:
- clock  input  1  rising-edge clock
- _reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  FIFO can accept; equals !full
- in_a  input  8  multiplicand, two's complement
- in_b  input  8  multiplier, two's complement
- mul_start  output  1  start level to multiplier interface unit
- mul_a  output  8  multiplicand to multiplier
- mul_b  output  8  multiplier operand to multiplier
- mul_done  input  1  multiplier done indication
- mul_result  input  16  multiplier product {P,B}
- out_valid  output  1  product available
- out_ready  input  1  consumer accepts product
- out_result  output  16  captured product
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: in_ready=1, mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_result=0, count=0, busy=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-operation aborts everything. The FIFO is emptied and mul_start drops immediately (asynchronous). Any in-flight product is discarded.
- FIFO push: in_valid && in_ready on a rising edge.
- FIFO pop: occurs only on WAIT→HOLD, or on timeout abort.
- Simultaneous push and pop: count is unchanged and both take effect.
- Push when full: ignored, because in_ready=0.
- Pointers wrap modulo DEPTH. count saturates nowhere and ranges 0..DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If count≠0 and mul_done=0, register FIFO head into mul_a/mul_b and go to ISSUE.
  - Otherwise stay in IDLE with mul_start=0.
- ISSUE:
  - Assert mul_start=1 (registered) for exactly 1 cycle, then go to WAIT.
  - mul_a/mul_b are held constant from ISSUE through the cycle of HOLD entry.
- WAIT:
  - mul_start=0.
  - On mul_done=1: capture out_result<=mul_result, pop FIFO, set out_valid=1, go to HOLD.
  - A mul_done seen in the first WAIT cycle is accepted.
- HOLD:
  - out_valid=1 with out_result stable.
  - On out_ready=1: out_valid<=0 and go to IDLE.
  - The next issue therefore occurs no earlier than 1 cycle after acceptance.
  - Minimum throughput is 4 cycles plus multiplier latency per product.
- out_result is a plain 16-bit capture with no sign manipulation. Signedness is the multiplier's responsibility.
- mul_done asserted outside WAIT is ignored. In IDLE, a high mul_done blocks a new issue until it falls, so no stale done is consumed.

Optional Feature:
- Macro: BOOTH_SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - On reaching TIMEOUT with no mul_done: pop the FIFO entry, set out_result=16'hDEAD, assert out_valid, set sticky output timeout_err=1, go to HOLD.
  - timeout_err clears only on reset.
- When undefined:
  - No counter and no timeout_err port.
  - WAIT waits indefinitely.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, HOLD=2'b11.
  - Operand width constant 8.
  - Product width constant 16.
  - Timeout sentinel 16'hDEAD.
- One sub-module: booth_operand_fifo. Synchronous DEPTH×16 FIFO with push/pop/full/empty/count and asynchronous active-low reset.
- The FSM and capture logic stay in the top level.

Test Plan:
- Single op: push a=8'h01, b=8'hF8; model multiplier answers after 20 cycles → exactly one mul_start pulse, then out_valid with out_result=16'hFFF8.
- Fill and back-pressure:
  - Push 5 pairs with DEPTH=4 and out_ready=0 → in_ready=0 after 4 pushes and the 5th is held.
  - Products for (3,5),(−2,7),(127,127),(−128,−128) emerge in order: 000F, FFF2, 3F01, 4000.
- Simultaneous push/pop: push in the same cycle as WAIT→HOLD with count=2 → count stays 2 and FIFO order is preserved.
- Stale done: hold mul_done=1 in IDLE with count=1 → no mul_start until mul_done falls.
- Reset mid-WAIT: drop _reset during WAIT with 3 entries queued → mul_start=0 and count=0 immediately; out_valid=0 after release.
- With BOOTH_SEQ_TIMEOUT_EN and TIMEOUT=64, multiplier never responds → after 64 WAIT cycles out_result=16'hDEAD, timeout_err=1, and the next entry then issues normally.
